// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: D = A - B, LSB first, one bit per clock.
// Uses a start/busy/done handshake with registered difference and flag outputs.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         bout,
  output logic         ovf,
  output logic         zero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic           accept_s;
  logic           last_s;

  logic [N-1:0]   sa_r;
  logic [N-1:0]   sb_r;
  logic [N-1:0]   sd_r;
  logic           br_r;
  logic [CW-1:0]  cnt_r;
  logic           amsb_r;
  logic           bmsb_r;

  logic           d_bit_s;
  logic           br_next_s;
  logic [N-1:0]   sd_next_s;
  logic           ovf_s;
  logic           zero_s;

  function automatic logic diff_bit(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  function automatic logic borrow_bit(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

  // Signed overflow: operands of opposite sign and result sign differs from the minuend.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state decode; also flags operand acceptance and the final bit edge.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
          last_s  = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // One-bit subtract slice plus the result/flag values seen on the final edge.
  always_comb begin
    d_bit_s   = diff_bit(sa_r[0], sb_r[0], br_r);
    br_next_s = borrow_bit(sa_r[0], sb_r[0], br_r);
    sd_next_s = {d_bit_s, sd_r[N-1:1]};
    zero_s    = (sd_next_s == {N{1'b0}});
    ovf_s     = sub_ovf(amsb_r, bmsb_r, sd_next_s[N-1]);
  end

  // Operand/result shift registers, borrow and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_r   <= {N{1'b0}};
      sb_r   <= {N{1'b0}};
      sd_r   <= {N{1'b0}};
      br_r   <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      amsb_r <= 1'b0;
      bmsb_r <= 1'b0;
    end else if (accept_s) begin
      sa_r   <= A;
      sb_r   <= B;
      sd_r   <= {N{1'b0}};
      br_r   <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      amsb_r <= A[N-1];
      bmsb_r <= B[N-1];
    end else if (state_r == RUN) begin
      sa_r  <= {1'b0, sa_r[N-1:1]};
      sb_r  <= {1'b0, sb_r[N-1:1]};
      sd_r  <= sd_next_s;
      br_r  <= br_next_s;
      // Counter holds on the final bit so it never wraps within an operation.
      if (!last_s) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Registered handshake and result outputs; results only update on the RUN->DONE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      D    <= {N{1'b0}};
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      busy <= (state_s == RUN);
      done <= (state_s == DONE);
      if (last_s) begin
        D    <= sd_next_s;
        bout <= br_next_s;
        ovf  <= ovf_s;
        zero <= zero_s;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (N=4): directed vectors, handshake,
// reset behaviour and an exhaustive sweep, checked by a separate monitor.
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] D;
  logic         bout;
  logic         ovf;
  logic         zero;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       bo;
    logic       ov;
    logic       z;
  } exp_t;

  exp_t       sb[$];
  int         checks;
  int         errors;
  logic [3:0] held_d;

  serial_subtractor #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .D(D), .bout(bout), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy || done) chk("busy_done_exclusive", 32'(busy & done), 32'd0);
        if (busy) chk("d_stable_while_busy", 32'(D), 32'(held_d));
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("D",    32'(D),    32'(e.d));
            chk("bout", 32'(bout), 32'(e.bo));
            chk("ovf",  32'(ovf),  32'(e.ov));
            chk("zero", 32'(zero), 32'(e.z));
            chk("inverse_D_plus_B", 32'((D + e.b) & 4'hF), 32'(e.a));
          end
          held_d = D;
        end
      end
    end
  endtask

  task automatic all_zero_check(input string name);
    chk(name, 32'({busy, done, D, bout, ovf, zero}), 32'd0);
  endtask

  // Issue one operation, push its expectation, wait (bounded) for done.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic bo, input logic ov, input logic z);
    exp_t e;
    int   lat;
    e.a = a; e.b = b; e.d = d; e.bo = bo; e.ov = ov; e.z = z;
    A = a; B = b; start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~a; B = ~b;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    else chk("latency", 32'(lat), 32'(N + 1));
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int   sa, sbv, diff;
    sa   = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sbv  = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    diff = sa - sbv;
    e.a  = a;
    e.b  = b;
    e.d  = 4'((int'(a) - int'(b) + 16) % 16);
    e.bo = (a < b);
    e.ov = (diff < -8) || (diff > 7);
    e.z  = (e.d == 4'd0);
    return e;
  endfunction

  task automatic stimulus();
    exp_t  e;
    int    dcnt;
    time   t_done[$];
    // Reset state
    rst = 1'b1; start = 1'b0; A = 4'd0; B = 4'd0; held_d = 4'd0;
    #1;
    all_zero_check("reset_initial");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(4'b0100, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0);
    // Asynchronous reset between edges clears outputs immediately
    @(posedge clk);
    #3;
    rst = 1'b1;
    held_d = 4'd0;
    #1;
    all_zero_check("reset_async");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    // Basic and borrow-chain vectors
    run_op(4'b1000, 4'b0010, 4'b0110, 1'b0, 1'b1, 1'b0);
    run_op(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
    run_op(4'b0100, 4'b1000, 4'b1100, 1'b1, 1'b1, 1'b0);
    run_op(4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0);
    run_op(4'b0010, 4'b1000, 4'b1010, 1'b1, 1'b1, 1'b0);
    // start held high: three operations spaced N+2 cycles apart
    e.a = 4'b0111; e.b = 4'b0101; e.d = 4'b0010; e.bo = 1'b0; e.ov = 1'b0; e.z = 1'b0;
    for (int k = 0; k < 3; k++) sb.push_back(e);
    A = 4'b0111; B = 4'b0101; start = 1'b1;
    for (int i = 0; i < 40 && t_done.size() < 3; i++) begin
      @(negedge clk);
      if (done) t_done.push_back($time);
    end
    start = 1'b0;
    chk("b2b_done_count", 32'(t_done.size()), 32'd3);
    if (t_done.size() == 3) begin
      chk("b2b_spacing_1", 32'(t_done[1] - t_done[0]), 32'((N + 2) * 10));
      chk("b2b_spacing_2", 32'(t_done[2] - t_done[1]), 32'((N + 2) * 10));
    end
    @(posedge clk);
    #1;
    // Extra start pulses during busy are ignored
    e.a = 4'b1001; e.b = 4'b0011; e.d = 4'b0110; e.bo = 1'b0; e.ov = 1'b1; e.z = 1'b0;
    sb.push_back(e);
    A = 4'b1001; B = 4'b0011; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; A = 4'b0000; B = 4'b0001;
    dcnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      start = (i == 0) || (i == 2);
      @(negedge clk);
      if (done) dcnt++;
    end
    start = 1'b0;
    chk("extra_start_ignored", 32'(dcnt), 32'd1);
    @(posedge clk);
    #1;
    // Reset mid-operation: no done, outputs cleared
    A = 4'b0110; B = 4'b0011; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    held_d = 4'd0;
    #1;
    all_zero_check("reset_mid_op");
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("no_done_after_abort", 32'(dcnt), 32'd0);
    chk("d_after_abort", 32'(D), 32'd0);
    @(posedge clk);
    #1;
    run_op(4'b0110, 4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0);
    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        e = model(4'(a), 4'(b));
        run_op(e.a, e.b, e.d, e.bo, e.ov, e.z);
      end
    end
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fork
      monitor();
      stimulus();
      begin
        #500000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join_any
  end

endmodule
